// File: rtl/prm_edge_mask_eval.sv
// Sum-of-products edge-mask evaluator: per-edge tables of masked product terms,
// scanned LANES slots per cycle with the first matching slot reported.
module prm_edge_mask_eval #(
  parameter int NUM_IN    = 15,
  parameter int NUM_TERMS = 96,
  parameter int NUM_EDGES = 8,
  parameter int LANES     = 4,
  localparam int EW = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1,
  localparam int TW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1,
  localparam int G  = (NUM_TERMS + LANES - 1) / LANES,
  localparam int GW = $clog2(G + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [EW-1:0]     cfg_edge,
  input  logic [TW-1:0]     cfg_term,
  input  logic [NUM_IN-1:0] cfg_care,
  input  logic [NUM_IN-1:0] cfg_val,
  input  logic              cfg_en,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [EW-1:0]     q_edge,
  input  logic [NUM_IN-1:0] q_bits,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_mask,
  output logic              r_err,
  output logic [EW-1:0]     r_edge,
  output logic [TW-1:0]     r_term
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nx;

  logic [NUM_IN-1:0]    care_m [NUM_EDGES][NUM_TERMS];
  logic [NUM_IN-1:0]    val_m  [NUM_EDGES][NUM_TERMS];
  logic [NUM_TERMS-1:0] en_m   [NUM_EDGES];

  logic [EW-1:0]     qe;
  logic [NUM_IN-1:0] qb;
  logic [GW-1:0]     g;
  logic              pend_v, pend_hit, pend_last;
  logic [TW-1:0]     pend_idx;

  logic          q_acc, q_bad, wr_ok, grp_hit, grp_last;
  logic [TW-1:0] grp_idx;

  function automatic int unsigned slot_of(input int unsigned gi, input int unsigned l);
    return gi * LANES + l;
  endfunction

  always_comb begin
    cfg_ready = (state == IDLE) && !rst;
    // A simultaneous write wins the cycle; the query waits.
    q_ready   = cfg_ready && !cfg_we;
    q_acc     = q_valid && q_ready;
    q_bad     = 32'(q_edge) >= NUM_EDGES;
    wr_ok     = cfg_we && cfg_ready && (32'(cfg_edge) < NUM_EDGES) && (32'(cfg_term) < NUM_TERMS);
    grp_last  = (32'(g) == G - 1);
  end

  always_comb begin
    grp_hit = 1'b0;
    grp_idx = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!grp_hit && slot_of(32'(g), l) < NUM_TERMS &&
          en_m[qe][slot_of(32'(g), l)] &&
          (((qb ^ val_m[qe][slot_of(32'(g), l)]) & care_m[qe][slot_of(32'(g), l)]) == '0)) begin
        grp_hit = 1'b1;
        grp_idx = TW'(slot_of(32'(g), l));
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (q_acc) state_nx = q_bad ? DONE : SCAN;
      SCAN: if (pend_v && (pend_hit || pend_last)) state_nx = DONE;
      DONE: if (r_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      care_m[cfg_edge][cfg_term] <= cfg_care;
      val_m[cfg_edge][cfg_term]  <= cfg_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned e = 0; e < NUM_EDGES; e++) en_m[e] <= '0;
    end else if (wr_ok) begin
      en_m[cfg_edge][cfg_term] <= cfg_en;
    end
  end

  // Group matches are registered one cycle before they are resolved into the
  // result, so a group's verdict lands one edge after it is scanned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_mask    <= 1'b0;
      r_err     <= 1'b0;
      r_edge    <= '0;
      r_term    <= '0;
      qe        <= '0;
      qb        <= '0;
      g         <= '0;
      pend_v    <= 1'b0;
      pend_hit  <= 1'b0;
      pend_last <= 1'b0;
      pend_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_acc) begin
            qe     <= q_edge;
            qb     <= q_bits;
            g      <= '0;
            pend_v <= 1'b0;
            r_edge <= q_edge;
            r_err  <= q_bad;
            if (q_bad) begin
              r_valid <= 1'b1;
              r_mask  <= 1'b0;
              r_term  <= '1;
            end
          end
        end
        SCAN: begin
          pend_v    <= 1'b1;
          pend_hit  <= grp_hit;
          pend_idx  <= grp_idx;
          pend_last <= grp_last;
          g         <= g + 1'b1;
          if (pend_v && pend_hit) begin
            r_valid <= 1'b1;
            r_mask  <= 1'b1;
            r_term  <= pend_idx;
          end else if (pend_v && pend_last) begin
            r_valid <= 1'b1;
            r_mask  <= 1'b0;
            r_term  <= '1;
          end
        end
        DONE: if (r_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
